// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray/binary pointer helpers for the async FIFO
package fifo_pkg;

  localparam int FUNC_W = 32;

  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits pass through unchanged, so any width up to FUNC_W works.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b = g;
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational Gray-to-binary pointer converter
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(FUNC_W'(gray)));

endmodule

// File: rtl/wr_ptr_handlr.sv
// rtl/wr_ptr_handlr.sv - write-side pointer, full/almost-full, occupancy and overflow
module wr_ptr_handlr
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic                 wovf_clr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wcount,
  output logic                 woverflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] wcount_next;
  logic [ADDR_SIZE:0] full_ptr;
  logic               wfull_next;
  logic               walmost_full_next;
  logic               woverflow_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_SIZE-1:0];

  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = PW'(bin2gray(FUNC_W'(wbin_next)));

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_ptr          = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
  assign wfull_next        = (wgray_next == full_ptr);
  assign wcount_next       = wbin_next - rbin_s;
  assign walmost_full_next = (wcount_next >= AFULL_LVL);
  assign woverflow_next    = (winc & wfull) | (woverflow & ~wovf_clr);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wcount       <= wcount_next;
      woverflow    <= woverflow_next;
    end
  end

endmodule

// File: tb/tb_wr_ptr_handlr.sv
// tb/tb_wr_ptr_handlr.sv - scoreboard bench for wr_ptr_handlr against an occupancy model
module tb_wr_ptr_handlr;

  localparam int AS = 4;
  localparam int D  = 16;
  localparam int TH = 14;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  wr_ptr_handlr #(.ADDR_SIZE(AS), .AFULL_THRESH(TH)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit   chk;
    bit   gray_chk;
    bit   wen;
    int   waddr;
    int   wptr;
    bit   wfull;
    bit   wafull;
    int   wcount;
    bit   wovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model: total writes mod 32 and the read position, occupancy is their difference.
  int m_wr    = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  int m_count = 0;
  bit m_ovf   = 0;
  bit m_known = 0;
  bit m_prev_rst = 1;
  int rbin    = 0;
  int hist[$];

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input bit i_inc, input bit i_clr, input bit i_rst, input int i_rbin);
    exp_t e;
    bit   w;
    int   occ;
    @(posedge wclk);
    #1;
    winc     = i_inc;
    wovf_clr = i_clr;
    wrst     = i_rst;
    wq2_rptr = to_gray(i_rbin);
    w = i_inc && !m_full;
    e.chk      = m_known;
    e.gray_chk = m_known && !m_prev_rst;
    e.wen      = w;
    e.waddr    = m_wr % D;
    e.wptr     = int'(to_gray(m_wr));
    e.wfull    = m_full;
    e.wafull   = m_afull;
    e.wcount   = m_count;
    e.wovf     = m_ovf;
    sb.push_back(e);
    if (i_rst) begin
      m_wr = 0; m_full = 0; m_afull = 0; m_count = 0; m_ovf = 0; m_known = 1;
    end else begin
      m_ovf   = (i_inc && m_full) || (m_ovf && !i_clr);
      m_wr    = (m_wr + int'(w)) % 32;
      occ     = (m_wr - i_rbin + 32) % 32;
      m_full  = (occ == D);
      m_afull = (occ >= TH);
      m_count = occ;
    end
    m_prev_rst = i_rst;
  endtask

  logic [4:0] prev_wptr;

  initial begin
    exp_t e;
    prev_wptr = '0;
    forever begin
      @(negedge wclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          chk("wen", int'(wen), int'(e.wen));
          chk("waddr", int'(waddr), e.waddr);
          chk("wptr", int'(wptr), e.wptr);
          chk("wfull", int'(wfull), int'(e.wfull));
          chk("walmost_full", int'(walmost_full), int'(e.wafull));
          chk("wcount", int'(wcount), e.wcount);
          chk("woverflow", int'(woverflow), int'(e.wovf));
          if (e.gray_chk) chk("wptr_gray_step", int'($countones(wptr ^ prev_wptr) <= 1), 1);
        end
        prev_wptr = wptr;
      end
    end
  end

  initial begin
    int occ;
    bit r;
    // reset with a pending write
    repeat (2) step(1, 0, 1, 0);
    // fill to full, then overflow attempts
    repeat (16) step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    // release one slot and refill it
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    // wrap with the read pointer trailing two cycles
    step(0, 0, 1, 0);
    hist.delete();
    for (int i = 0; i < 42; i++) begin
      hist.push_back(m_wr);
      rbin = (hist.size() >= 3) ? hist[hist.size()-3] : 0;
      step(i < 40, 0, 0, rbin);
    end
    // mid-stream reset
    step(0, 0, 1, 0);
    repeat (9) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    // randomized traffic
    step(0, 0, 1, 0);
    rbin = 0;
    for (int i = 0; i < 400; i++) begin
      occ = (m_wr - rbin + 32) % 32;
      if (occ > 0 && $urandom_range(0, 2) == 0) rbin = (rbin + 1) % 32;
      r = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, r, rbin);
      if (r) rbin = 0;
    end
    step(0, 0, 0, rbin);
    repeat (4) @(negedge wclk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wr_ptr_handlr.md
# wr_ptr_handlr

Write-side pointer and flag generator for the asynchronous FIFO, the counterpart of the read-side pointer handler. It runs entirely in the write clock domain. It advances a binary/Gray write pointer on accepted writes and drives the memory write address and enable. It compares its pointer against the read pointer, which arrives already synchronised into the write domain, and from that produces full, almost-full, occupancy and a sticky overflow indication.

## Interface
- ADDR_SIZE, 4, memory address width; FIFO depth is 2^ADDR_SIZE and pointers are ADDR_SIZE+1 bits
- AFULL_THRESH, 2^ADDR_SIZE-2, occupancy at or above which walmost_full asserts; legal range 1..2^ADDR_SIZE
- wclk  input  1  write clock; the block's only clock
- wrst  input  1  reset, synchronous to wclk, active-high
- winc  input  1  write request
- wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already two-flop synchronised into wclk
- wovf_clr  input  1  clears woverflow
- wen  output  1  memory write enable, combinational: winc & ~wfull
- waddr  output  ADDR_SIZE  memory write address, wbin[ADDR_SIZE-1:0]
- wptr  output  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain synchroniser
- wfull  output  1  registered full flag
- walmost_full  output  1  registered almost-full flag
- wcount  output  ADDR_SIZE+1  registered occupancy as seen from the write side, range 0..2^ADDR_SIZE
- woverflow  output  1  sticky flag: a write was attempted while full

## Operation
- State: wbin and wptr (ADDR_SIZE+1 bits each), plus registered wfull, walmost_full, wcount and woverflow.
- wbin_next = wbin + wen. wgray_next = (wbin_next >> 1) ^ wbin_next. Both registers load every cycle. Arithmetic is modulo 2^(ADDR_SIZE+1).
- Full term: wfull_next = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
- Occupancy:
  - rbin_s = gray-to-binary of wq2_rptr, where bit i is the XOR of wq2_rptr[ADDR_SIZE:i].
  - wcount_next = wbin_next - rbin_s, modulo 2^(ADDR_SIZE+1).
  - walmost_full_next = (wcount_next >= AFULL_THRESH).
- Overflow: woverflow_next = (winc & wfull) | (woverflow & ~wovf_clr). If a set and a clear occur in the same cycle, the set wins.
- A write while full is dropped: wen=0 and the pointers hold. No other error action is taken.
- Flags are pessimistic by construction. wfull and wcount may overstate occupancy, because reads reach the write side only after synchroniser delay. They never understate it.
- Reset (wrst=1 at a wclk edge) overrides all other inputs, including winc and a reset arriving mid-stream:
  - wbin=0, wptr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0.
  - wen is combinational, so it follows winc during the reset cycle because wfull=0. The memory write that results is harmless, since the pointers are zeroed.

## Timing
- Write accepted at edge N when wen=1 in the cycle before N; the data is written at the waddr presented in that cycle.
- At edge N, waddr/wptr advance and wfull, walmost_full and wcount update.
- Zero-cycle decision: wen depends on the current wfull only, with no extra pipeline stage.
- Read-to-release latency equals the external synchroniser delay (2 wclk) plus 1 wclk for this block's registered flags.
- Back-to-back writes sustain one per cycle until full. The last writable slot is accepted, and wfull asserts on the same edge that stores it.
- wptr changes by at most one bit per edge (Gray property). This is required for the CDC path.
- Wrap-around: waddr rolls from 2^ADDR_SIZE-1 to 0 and the pointer MSB toggles. The full/empty distinction relies solely on the MSB and MSB-1 inversion.

## Structure
- Shared package fifo_pkg holds the bin2gray and gray2bin functions, parameterised by width. The read-side handler uses the same package.
- One natural sub-module: gray2bin_conv, a combinational ADDR_SIZE+1-bit converter instantiated for wq2_rptr. Everything else sits inline in wr_ptr_handlr.

## Test plan
All scenarios use ADDR_SIZE=4 and AFULL_THRESH=14.
1. Reset: hold wrst=1 for 2 cycles with winc=1 and wq2_rptr=0 -> wptr=0, waddr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0.
2. Fill: wq2_rptr=0, winc=1 for 16 cycles -> wcount steps 1..16; walmost_full rises when wcount=14; wfull rises when wcount=16; then wptr=5'b11000, waddr=0 and wen=0.
3. Overflow: while full, winc=1 for 3 cycles -> wptr holds 5'b11000 and woverflow=1 from the next edge. Pulse wovf_clr alone -> woverflow=0. Assert wovf_clr together with winc while full -> woverflow stays 1.
4. Release: from full, set wq2_rptr=5'b00001 (binary 1) -> the next edge gives wfull=0 and wcount=15. One write is then accepted and wfull reasserts with wcount=16.
5. Wrap: 40 writes with wq2_rptr following wptr 2 cycles late -> wfull never asserts; waddr wraps 15->0 twice; every wptr change is a single bit; wptr MSB toggles at writes 16 and 32.
6. Mid-stream reset: after 9 writes (wcount=9), assert wrst for 1 cycle with winc=1 -> all registered outputs are 0 on that edge. Writing resumes from waddr=0 the cycle after.
